// File: rtl/hello_scroll_ctrl_if.sv
// hello_scroll_ctrl_if: pin bundle for the HELLO banner sequencer.
//   SW[17:15]  run / dir / fast level switches (into the sequencer)
//   KEY1_N     step pushbutton, active-low (into the sequencer)
//   HEX4..HEX0 active-low segment drive {g,f,e,d,c,b,a} (out of the sequencer)
//   PHASE      current rotation phase 0..4 (out of the sequencer)
// master = board/stimulus side, slave = sequencer side.
interface hello_scroll_ctrl_if;
  logic [17:15] SW;
  logic         KEY1_N;
  logic [6:0]   HEX4, HEX3, HEX2, HEX1, HEX0;
  logic [2:0]   PHASE;

  modport master (output SW, KEY1_N, input HEX4, HEX3, HEX2, HEX1, HEX0, PHASE);
  modport slave  (input SW, KEY1_N, output HEX4, HEX3, HEX2, HEX1, HEX0, PHASE);
endinterface

// File: rtl/hello_scroll_ctrl.sv
// hello_scroll_ctrl: rotating "HELLO" banner sequencer for HEX4..HEX0.
//   CLOCK_50  system clock, rising edge
//   RST_N     asynchronous active-low reset, synchronous release
//   io        hello_scroll_ctrl_if.slave: SW[17:15], KEY1_N in; HEX4..HEX0, PHASE out
// Parameter DIV: slow tick period in cycles (>= 4, even); fast period is DIV/2.
// Optional macro HELLO_BLINK_EN: a wrapping tick in RUN blanks the display for
// one tick period (FLASH) before resuming.
module hello_scroll_ctrl #(
  parameter int DIV = 25_000_000
) (
  input  logic               CLOCK_50,
  input  logic               RST_N,
  hello_scroll_ctrl_if.slave io
);

  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] LIM_S1 = CW'(DIV - 1);
  localparam logic [CW-1:0] LIM_F1 = CW'(DIV / 2 - 1);

  localparam logic [6:0] G_H   = 7'b0001001;
  localparam logic [6:0] G_E   = 7'b0000110;
  localparam logic [6:0] G_L   = 7'b1000111;
  localparam logic [6:0] G_O   = 7'b1000000;
  localparam logic [6:0] G_BLK = 7'b1111111;

  typedef enum logic [1:0] {BLANK, RUN, HOLD, FLASH} state_t;

  state_t          state_q, state_nxt;
  logic [2:0]      phase_q, phase_nxt, phase_step;
  logic [CW-1:0]   cnt_q, cnt_nxt;
  logic [4:0][6:0] hex_q, hex_nxt;
  logic            blank_nxt;

  // synchronizers; idle levels are switches off, key released
  logic [2:0] sw_s1, sw_s2;
  logic       key_s1, key_s2, key_s3, press;
  logic       run, dir, fast, tick, wrap;

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
      key_s3 <= 1'b1;
      press  <= 1'b0;
    end else begin
      sw_s1  <= io.SW;
      sw_s2  <= sw_s1;
      key_s1 <= io.KEY1_N;
      key_s2 <= key_s1;
      key_s3 <= key_s2;
      // registered 1->0 detect: one-cycle pulse, third edge after the pin falls
      press  <= key_s3 & ~key_s2;
    end
  end

  assign run  = sw_s2[2];
  assign dir  = sw_s2[1];
  assign fast = sw_s2[0];

  // >= rather than == so that switching to fast with the count already past
  // the short limit fires at once instead of wrapping the counter
  assign tick = cnt_q >= (fast ? LIM_F1 : LIM_S1);
  assign wrap = dir ? (phase_q == 3'd0) : (phase_q == 3'd4);

  always_comb begin
    phase_step = '0;
    if (dir) phase_step = (phase_q == 3'd0) ? 3'd4 : phase_q - 3'd1;
    else     phase_step = (phase_q == 3'd4) ? 3'd0 : phase_q + 3'd1;
  end

  always_comb begin
    state_nxt = state_q;
    phase_nxt = phase_q;
    cnt_nxt   = '0;
    case (state_q)
      BLANK: begin
        if (run)        state_nxt = RUN;
        else if (press) state_nxt = HOLD;
      end
      RUN: begin
        if (!run) begin
          state_nxt = HOLD;
        end else begin
          cnt_nxt = tick ? '0 : cnt_q + CW'(1);
          if (tick) begin
            phase_nxt = phase_step;
`ifdef HELLO_BLINK_EN
            if (wrap) state_nxt = FLASH;
`endif
          end
        end
      end
      HOLD: begin
        // run wins over a coincident press
        if (run)        state_nxt = RUN;
        else if (press) phase_nxt = phase_step;
      end
`ifdef HELLO_BLINK_EN
      FLASH: begin
        // phase already holds the wrapped value; just wait one period
        if (!run) begin
          state_nxt = HOLD;
        end else begin
          cnt_nxt = tick ? '0 : cnt_q + CW'(1);
          if (tick) state_nxt = RUN;
        end
      end
`endif
      default: state_nxt = BLANK;
    endcase
  end

  assign blank_nxt = (state_nxt == BLANK) || (state_nxt == FLASH);

  function automatic logic [6:0] glyph(input logic [2:0] idx);
    case (idx)
      3'd0:    glyph = G_H;
      3'd1:    glyph = G_E;
      3'd2:    glyph = G_L;
      3'd3:    glyph = G_L;
      default: glyph = G_O;
    endcase
  endfunction

  function automatic logic [2:0] rot(input logic [2:0] p, input logic [2:0] ofs);
    logic [3:0] s;
    s = {1'b0, p} + {1'b0, ofs};
    rot = (s >= 4'd5) ? 3'(s - 4'd5) : s[2:0];
  endfunction

  // digit i (HEX4 = 4 .. HEX0 = 0) shows C[(p + 4 - i) % 5]
  for (genvar i = 0; i < 5; i++) begin : g_dig
    assign hex_nxt[i] = blank_nxt ? G_BLK : glyph(rot(phase_nxt, 3'(4 - i)));
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= BLANK;
      phase_q <= '0;
      cnt_q   <= '0;
      hex_q   <= '1;
    end else begin
      state_q <= state_nxt;
      phase_q <= phase_nxt;
      cnt_q   <= cnt_nxt;
      hex_q   <= hex_nxt;
    end
  end

  assign io.HEX4  = hex_q[4];
  assign io.HEX3  = hex_q[3];
  assign io.HEX2  = hex_q[2];
  assign io.HEX1  = hex_q[1];
  assign io.HEX0  = hex_q[0];
  assign io.PHASE = phase_q;

endmodule

// File: tb/tb_hello_scroll_ctrl.sv
module tb_hello_scroll_ctrl;
  localparam int DIV = 8;

  localparam logic [6:0] H = 7'b0001001;
  localparam logic [6:0] E = 7'b0000110;
  localparam logic [6:0] L = 7'b1000111;
  localparam logic [6:0] O = 7'b1000000;
  localparam logic [6:0] B = 7'b1111111;

  localparam logic [34:0] W_BLANK = {B, B, B, B, B};
  localparam logic [34:0] W_HELLO = {H, E, L, L, O};
  localparam logic [34:0] W_ELLOH = {E, L, L, O, H};
  localparam logic [34:0] W_LOHEL = {L, O, H, E, L};
  localparam logic [34:0] W_OHELL = {O, H, E, L, L};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  hello_scroll_ctrl_if io();

  hello_scroll_ctrl #(.DIV(DIV)) dut (
    .CLOCK_50 (clk),
    .RST_N    (rst_n),
    .io       (io)
  );

  always #5 clk = ~clk;

  wire [34:0] hex_all = {io.HEX4, io.HEX3, io.HEX2, io.HEX1, io.HEX0};

  // stimulus helpers (no checking)
  task automatic apply_reset();
    rst_n = 1'b0;
    io.SW = 3'b000;
    io.KEY1_N = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_press();
    io.KEY1_N = 1'b0;
    repeat (4) @(negedge clk);
    io.KEY1_N = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    tests++;
    if (hex_all !== W_BLANK || io.PHASE !== 3'd0) begin
      fails++;
      $display("FAIL reset_state: hex=%h phase=%0d, want hex=%h phase=0", hex_all, io.PHASE, W_BLANK);
    end
    repeat (100) @(negedge clk);
    tests++;
    if (hex_all !== W_BLANK || io.PHASE !== 3'd0) begin
      fails++;
      $display("FAIL blank_idle: hex=%h phase=%0d, want hex=%h phase=0", hex_all, io.PHASE, W_BLANK);
    end
  endtask

  task automatic test_first_press();
    io.KEY1_N = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (hex_all !== W_BLANK) begin
      fails++;
      $display("FAIL press_latency_early: hex=%h, want %h", hex_all, W_BLANK);
    end
    @(negedge clk);
    tests++;
    if (hex_all !== W_HELLO || io.PHASE !== 3'd0) begin
      fails++;
      $display("FAIL press_shows_hello: hex=%h phase=%0d, want hex=%h phase=0", hex_all, io.PHASE, W_HELLO);
    end
    io.KEY1_N = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // HOLD at phase 0 -> run forward; phase 1 visible 11 negedges after SW set
  task automatic test_run_forward();
    int exp_p;
    io.SW = 3'b100;
    repeat (10) @(negedge clk);
    tests++;
    if (io.PHASE !== 3'd0) begin
      fails++;
      $display("FAIL first_tick_early: phase=%0d, want 0", io.PHASE);
    end
    for (int k = 11; k <= 42; k++) begin
      @(negedge clk);
      exp_p = (k - 11) / 8 + 1;
      tests++;
      if (io.PHASE !== 3'(exp_p)) begin
        fails++;
        $display("FAIL run_phase_k%0d: phase=%0d, want %0d", k, io.PHASE, exp_p);
      end
      if (k == 27) begin
        tests++;
        if (hex_all !== W_LOHEL) begin
          fails++;
          $display("FAIL hex_phase3: hex=%h, want %h", hex_all, W_LOHEL);
        end
      end
    end
  endtask

  // continues the run above: the 4 -> 0 tick lands at the next negedge
  task automatic test_wrap();
    @(negedge clk);
    tests++;
`ifdef HELLO_BLINK_EN
    if (hex_all !== W_BLANK || io.PHASE !== 3'd0) begin
      fails++;
      $display("FAIL wrap_flash_start: hex=%h phase=%0d, want hex=%h phase=0", hex_all, io.PHASE, W_BLANK);
    end
`else
    if (hex_all !== W_HELLO || io.PHASE !== 3'd0) begin
      fails++;
      $display("FAIL wrap_immediate: hex=%h phase=%0d, want hex=%h phase=0", hex_all, io.PHASE, W_HELLO);
    end
`endif
    repeat (7) @(negedge clk);
    tests++;
`ifdef HELLO_BLINK_EN
    if (hex_all !== W_BLANK || io.PHASE !== 3'd0) begin
      fails++;
      $display("FAIL wrap_flash_end: hex=%h phase=%0d, want hex=%h phase=0", hex_all, io.PHASE, W_BLANK);
    end
`else
    if (hex_all !== W_HELLO || io.PHASE !== 3'd0) begin
      fails++;
      $display("FAIL wrap_hold_0: hex=%h phase=%0d, want hex=%h phase=0", hex_all, io.PHASE, W_HELLO);
    end
`endif
    @(negedge clk);
    tests++;
`ifdef HELLO_BLINK_EN
    if (hex_all !== W_HELLO || io.PHASE !== 3'd0) begin
      fails++;
      $display("FAIL flash_resume: hex=%h phase=%0d, want hex=%h phase=0", hex_all, io.PHASE, W_HELLO);
    end
`else
    if (hex_all !== W_ELLOH || io.PHASE !== 3'd1) begin
      fails++;
      $display("FAIL wrap_next_step: hex=%h phase=%0d, want hex=%h phase=1", hex_all, io.PHASE, W_ELLOH);
    end
`endif
    io.SW = 3'b000;
  endtask

  task automatic test_reverse_hold();
    apply_reset();
    do_press();
    io.SW = 3'b010;
    repeat (3) @(negedge clk);
    do_press();
    tests++;
    if (io.PHASE !== 3'd4 || hex_all !== W_OHELL) begin
      fails++;
      $display("FAIL rev_press1: phase=%0d hex=%h, want phase=4 hex=%h", io.PHASE, hex_all, W_OHELL);
    end
    do_press();
    tests++;
    if (io.PHASE !== 3'd3 || hex_all !== W_LOHEL) begin
      fails++;
      $display("FAIL rev_press2: phase=%0d hex=%h, want phase=3 hex=%h", io.PHASE, hex_all, W_LOHEL);
    end
  endtask

  // BLANK -> RUN, then fast asserted so it is seen with count 6
  task automatic test_fast();
    apply_reset();
    io.SW = 3'b100;
    repeat (2) @(negedge clk);
    tests++;
    if (hex_all !== W_BLANK) begin
      fails++;
      $display("FAIL run_entry_early: hex=%h, want %h", hex_all, W_BLANK);
    end
    @(negedge clk);
    tests++;
    if (hex_all !== W_HELLO || io.PHASE !== 3'd0) begin
      fails++;
      $display("FAIL run_entry: hex=%h phase=%0d, want hex=%h phase=0", hex_all, io.PHASE, W_HELLO);
    end
    repeat (4) @(negedge clk);
    io.SW = 3'b101;
    repeat (2) @(negedge clk);
    tests++;
    if (io.PHASE !== 3'd0) begin
      fails++;
      $display("FAIL fast_pre: phase=%0d, want 0", io.PHASE);
    end
    @(negedge clk);
    tests++;
    if (io.PHASE !== 3'd1) begin
      fails++;
      $display("FAIL fast_immediate_tick: phase=%0d, want 1", io.PHASE);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (io.PHASE !== 3'd1) begin
      fails++;
      $display("FAIL fast_period_hold: phase=%0d, want 1", io.PHASE);
    end
    @(negedge clk);
    tests++;
    if (io.PHASE !== 3'd2) begin
      fails++;
      $display("FAIL fast_period_tick: phase=%0d, want 2", io.PHASE);
    end
    repeat (4) @(negedge clk);
    tests++;
    if (io.PHASE !== 3'd3) begin
      fails++;
      $display("FAIL fast_period_2: phase=%0d, want 3", io.PHASE);
    end
    io.SW = 3'b000;
  endtask

  task automatic test_async_reset();
    apply_reset();
    io.SW = 3'b100;
    repeat (20) @(negedge clk);
    tests++;
    if (io.PHASE !== 3'd2) begin
      fails++;
      $display("FAIL pre_reset_phase: phase=%0d, want 2", io.PHASE);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (hex_all !== W_BLANK || io.PHASE !== 3'd0) begin
      fails++;
      $display("FAIL async_reset: hex=%h phase=%0d, want hex=%h phase=0", hex_all, io.PHASE, W_BLANK);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (hex_all !== W_HELLO || io.PHASE !== 3'd0) begin
      fails++;
      $display("FAIL restart_run: hex=%h phase=%0d, want hex=%h phase=0", hex_all, io.PHASE, W_HELLO);
    end
    repeat (8) @(negedge clk);
    tests++;
    if (io.PHASE !== 3'd1) begin
      fails++;
      $display("FAIL restart_first_tick: phase=%0d, want 1", io.PHASE);
    end
    io.SW = 3'b000;
  endtask

  // HOLD at 0: press pulse and run arrive in the same cycle; run wins
  task automatic test_back_to_back();
    apply_reset();
    do_press();
    io.KEY1_N = 1'b0;
    @(negedge clk);
    io.SW = 3'b100;
    repeat (3) @(negedge clk);
    tests++;
    if (io.PHASE !== 3'd0 || hex_all !== W_HELLO) begin
      fails++;
      $display("FAIL run_beats_press: phase=%0d hex=%h, want phase=0 hex=%h", io.PHASE, hex_all, W_HELLO);
    end
    io.KEY1_N = 1'b1;
    repeat (7) @(negedge clk);
    tests++;
    if (io.PHASE !== 3'd0) begin
      fails++;
      $display("FAIL prescaler_from_zero_early: phase=%0d, want 0", io.PHASE);
    end
    @(negedge clk);
    tests++;
    if (io.PHASE !== 3'd1) begin
      fails++;
      $display("FAIL prescaler_from_zero: phase=%0d, want 1", io.PHASE);
    end
    io.KEY1_N = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (io.PHASE !== 3'd1) begin
      fails++;
      $display("FAIL press_in_run_ignored: phase=%0d, want 1", io.PHASE);
    end
    io.KEY1_N = 1'b1;
    io.SW = 3'b000;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    io.SW = 3'b000;
    io.KEY1_N = 1'b1;
    test_reset();
    test_first_press();
    test_run_forward();
    test_wrap();
    test_reverse_hold();
    test_fast();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hello_scroll_ctrl.md
# hello_scroll_ctrl

Sequencer for the five-digit "HELLO" rotating banner on HEX4..HEX0. The block owns the rotation phase (0..4). In run mode it advances the phase automatically from a prescaled CLOCK_50 tick. In hold mode it steps the phase one position per pushbutton press. It drives the active-low seven-segment outputs from registers, so the banner scrolls without manual switch changes.

## Interface
- DIV, 25_000_000, slow-mode tick period in clock cycles (0.5 s at 50 MHz); must be ≥ 4 and even; benches use 8
- CLOCK_50  in  1  single system clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- SW  in  [17:15]  SW[17] run (1 = auto-scroll), SW[16] dir (0 = forward, 1 = reverse), SW[15] fast (1 = period DIV/2); level inputs, synchronized internally
- KEY1_N  in  1  step pushbutton, active-low, asynchronous to clock
- HEX4..HEX0  out  7 each  segment drive, active-low, {g,f,e,d,c,b,a}
- PHASE  out  3  current rotation phase 0..4, for LEDG

## Operation
- Glyphs: H = 7'b0001001, E = 7'b0000110, L = 7'b1000111, O = 7'b1000000, blank = 7'b1111111.
- Display of phase p: HEX4..HEX0 = C[(p+0)%5] .. C[(p+4)%5], where C = H,E,L,L,O.
  - p = 1 gives ELLOH.
  - p = 4 gives OHELL.
- Phase step:
  - forward: p+1, with 4 → 0
  - reverse: p−1, with 0 → 4
  - PHASE never takes values 5..7.
- Inputs: SW[17:15] and KEY1_N each pass through a 2-flop synchronizer. A step press is a 1→0 edge of synchronized KEY1_N; it generates a one-cycle pulse.
- States:
  - BLANK (reset state): all HEX blank, PHASE = 0. If run = 1, go to RUN. Else, on a press, go to HOLD with the phase unchanged (shows HELLO).
  - RUN: prescaler counts. On each tick, step the phase in dir. If run = 0, go to HOLD; the phase freezes and the prescaler clears.
  - HOLD: phase displayed. Each press steps the phase once in dir. If run = 1, go to RUN with the prescaler starting at 0.
  - FLASH (only with HELLO_BLINK_EN): see Configuration.
- Press in RUN: ignored.
- Run and press in the same cycle in HOLD: run wins, and the press is dropped.
- Prescaler:
  - limit = fast ? DIV/2 : DIV.
  - Counts 0..limit−1 in RUN only; the tick fires when count ≥ limit−1, then count resets to 0.
  - Toggling fast mid-count never stalls: with count beyond the new limit, the tick fires on the next cycle.
- dir is sampled at the tick or press cycle. Changing dir mid-period does not reset the prescaler.

## Timing
- Reset (asynchronous assert, any state, including mid-FLASH): state BLANK, PHASE = 0, prescaler = 0, HEX4..HEX0 = 7'h7F, synchronizers cleared to the idle level (KEY1_N = 1, SW = 0). Release is synchronous.
- HEX and PHASE are registered. The display reflects a new phase 1 cycle after the tick or press cycle.
- KEY1_N falling at the pins → phase change visible on HEX after 4 clock edges (2 sync + edge detect + output register).
- SW[17] rising in BLANK/HOLD → RUN after 3 edges. The first tick follows limit cycles later.
- Tick period is exactly DIV cycles (slow) or DIV/2 cycles (fast). No jitter while the period is steady.
- No debounce is applied. Bounce produces multiple steps; the board-level button is assumed clean.

## Configuration
- HELLO_BLINK_EN defined:
  - In RUN, a tick that wraps the phase (4 → 0 forward, 0 → 4 reverse) enters FLASH.
  - FLASH blanks all digits for one full tick period while PHASE already holds the new value.
  - The next tick returns to RUN and shows that phase without stepping.
  - run = 0 during FLASH goes to HOLD and shows the phase.
  - Steps in HOLD never flash.
- HELLO_BLINK_EN undefined: FLASH does not exist. A wrap displays the new phase immediately, like any other step.

## Test plan
- Reset, then run = 0 and no press for 100 cycles → all HEX = 7'h7F, PHASE = 0. One press → HEX4..HEX0 = H,E,L,L,O, PHASE = 0.
- DIV = 8, run = 1, dir = 0, fast = 0 → PHASE sequence 1,2,3,4,0,1 with each value stable 8 cycles. PHASE = 3 shows L,O,H,E,L.
- HOLD at PHASE = 0, dir = 1, two presses → PHASE 4 then 3. HEX at PHASE 4 = O,H,E,L,L.
- RUN with DIV = 8, set fast = 1 at count 6 → tick on the next cycle, then a 4-cycle period.
- Macro defined, DIV = 8, forward RUN → on the 4 → 0 tick: HEX = 7'h7F and PHASE = 0 for 8 cycles, then HELLO. Macro undefined: HELLO immediately.
- Assert RST_N low mid-RUN at PHASE = 2 → HEX blank and PHASE = 0 within the same cycle, without waiting for a clock edge. Release with run = 1 → scrolling restarts from phase 0.
